bp_me_burst_mem_slave: RTL and testbench

BP_ME_BURST_MEM_SLAVE -- requirements
Module: bp_me_burst_mem_slave

---
 rtl/bp_me_pkg.sv | 97 +++++++++
 rtl/bp_me_burst_addr_gen.sv | 40 ++++
 rtl/bp_me_burst_mem_slave.sv | 161 ++++++++++++++++
 tb/tb_bp_me_burst_mem_slave.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/bp_me_pkg.sv
`default_nettype none
// ============================================================================
// bp_me_pkg: configuration, BedRock header layout and burst helpers
// Revision: 1.0
// ============================================================================
package bp_me_pkg;

   typedef enum logic {e_bp_default_cfg = 1'b0} bp_params_e;

   function automatic int bp_paddr_width(input bp_params_e cfg);
      case (cfg)
         e_bp_default_cfg: return 40;
         default:          return 40;
      endcase
   endfunction

   function automatic int bp_cce_block_width(input bp_params_e cfg);
      case (cfg)
         e_bp_default_cfg: return 512;
         default:          return 512;
      endcase
   endfunction

   function automatic int bp_lce_id_width(input bp_params_e cfg);
      case (cfg)
         e_bp_default_cfg: return 4;
         default:          return 4;
      endcase
   endfunction

   function automatic int bp_lce_assoc(input bp_params_e cfg);
      case (cfg)
         e_bp_default_cfg: return 8;
         default:          return 8;
      endcase
   endfunction

   function automatic int bp_mem_header_width(input int paddr_w, input int lce_id_w, input int assoc);
      return 4 + 4 + paddr_w + 3 + lce_id_w + $clog2(assoc);
   endfunction

   // N = max(1, 2^size/8); wrap offset stays inside the naturally aligned region
   function automatic int bp_me_beats(input logic [2:0] size);
      return (size <= 3'd3) ? 1 : (1 << (size - 3'd3));
   endfunction

   function automatic int bp_me_wrap(input int start, input int idx, input int beats);
      return (start + idx) & (beats - 1);
   endfunction

   localparam int dword_width_gp  = 64;
   localparam int paddr_width_gp  = bp_paddr_width(e_bp_default_cfg);
   localparam int lce_id_width_gp = bp_lce_id_width(e_bp_default_cfg);
   localparam int lce_assoc_gp    = bp_lce_assoc(e_bp_default_cfg);

   typedef enum logic [3:0] {
      e_bedrock_mem_rd    = 4'd0,
      e_bedrock_mem_wr    = 4'd1,
      e_bedrock_mem_uc_rd = 4'd2,
      e_bedrock_mem_uc_wr = 4'd3,
      e_bedrock_mem_pre   = 4'd4,
      e_bedrock_mem_amo   = 4'd5
   } bp_bedrock_mem_type_e;

   typedef enum logic [2:0] {
      e_bedrock_msg_size_1   = 3'd0,
      e_bedrock_msg_size_2   = 3'd1,
      e_bedrock_msg_size_4   = 3'd2,
      e_bedrock_msg_size_8   = 3'd3,
      e_bedrock_msg_size_16  = 3'd4,
      e_bedrock_msg_size_32  = 3'd5,
      e_bedrock_msg_size_64  = 3'd6,
      e_bedrock_msg_size_128 = 3'd7
   } bp_bedrock_msg_size_e;

   typedef struct packed {
      logic [lce_id_width_gp-1:0]       lce_id;
      logic [$clog2(lce_assoc_gp)-1:0]  way_id;
   } bp_bedrock_mem_payload_s;

   typedef struct packed {
      bp_bedrock_mem_payload_s     payload;
      bp_bedrock_msg_size_e        size;
      logic [paddr_width_gp-1:0]   addr;
      logic [3:0]                  subop;
      bp_bedrock_mem_type_e        msg_type;
   } bp_bedrock_mem_header_s;

   typedef logic [2:0] bp_me_state_t;
   localparam bp_me_state_t e_ready      = 3'd0;
   localparam bp_me_state_t e_write      = 3'd1;
   localparam bp_me_state_t e_resp_hdr   = 3'd2;
   localparam bp_me_state_t e_read_issue = 3'd3;
   localparam bp_me_state_t e_read_data  = 3'd4;

endpackage
`default_nettype wire

// File: rtl/bp_me_burst_addr_gen.sv
`default_nettype none
// ============================================================================
// bp_me_burst_addr_gen: critical-word-first dword address and byte mask
// Revision: 1.0
// ============================================================================
module bp_me_burst_addr_gen
   import bp_me_pkg::*;
#(
   parameter int paddr_width_p = 40,
   parameter int cnt_width_p   = 4,
   parameter int mask_width_p  = 8
)
(
   input  logic [paddr_width_p-1:0] addr_i,
   input  logic [2:0]               size_i,
   input  logic [cnt_width_p-1:0]   cnt_i,
   output logic [paddr_width_p-4:0] ram_addr_o,
   output logic [mask_width_p-1:0]  mask_o,
   output logic                     last_o
);
   localparam int dword_addr_width_lp = paddr_width_p - 3;

   logic [dword_addr_width_lp-1:0] dword_addr;
   logic [cnt_width_p-1:0]         wrap_mask;
   logic [cnt_width_p-1:0]         offset;
   logic [mask_width_p-1:0]        byte_ones;

   assign dword_addr = addr_i[paddr_width_p-1:3];
   assign wrap_mask  = cnt_width_p'(bp_me_beats(size_i) - 1);
   assign offset     = cnt_width_p'(bp_me_wrap(int'(dword_addr[cnt_width_p-1:0]), int'(cnt_i),
                                               bp_me_beats(size_i)));
   assign ram_addr_o = (dword_addr & ~dword_addr_width_lp'(wrap_mask)) | dword_addr_width_lp'(offset);
   assign last_o     = (cnt_i == wrap_mask);

   // Multi-beat bursts write whole dwords; single-beat writes touch only their bytes
   assign byte_ones  = (size_i >= 3'd3) ? '1 : mask_width_p'((1 << (1 << size_i)) - 1);
   assign mask_o     = (size_i > 3'd3) ? '1 : (byte_ones << addr_i[2:0]);

endmodule
`default_nettype wire

// File: rtl/bp_me_burst_mem_slave.sv
`default_nettype none
// ============================================================================
// bp_me_burst_mem_slave: BedRock burst memory command slave onto a 1-cycle RAM
// Revision: 1.0
// ============================================================================
module bp_me_burst_mem_slave
   import bp_me_pkg::*;
#(
   parameter bp_params_e bp_params_p = e_bp_default_cfg,
   localparam int paddr_width_p      = bp_paddr_width(bp_params_p),
   localparam int cce_block_width_p  = bp_cce_block_width(bp_params_p),
   localparam int lce_id_width_p     = bp_lce_id_width(bp_params_p),
   localparam int lce_assoc_p        = bp_lce_assoc(bp_params_p),
   localparam int cce_mem_msg_header_width_lp = bp_mem_header_width(paddr_width_p, lce_id_width_p, lce_assoc_p)
)
(
   input  logic                                   clk_i,
   input  logic                                   reset_i,

   input  logic [cce_mem_msg_header_width_lp-1:0] mem_cmd_header_i,
   input  logic                                   mem_cmd_header_v_i,
   output logic                                   mem_cmd_header_ready_and_o,
   input  logic                                   mem_cmd_has_data_i,
   input  logic [dword_width_gp-1:0]              mem_cmd_data_i,
   input  logic                                   mem_cmd_data_v_i,
   output logic                                   mem_cmd_data_ready_and_o,
   input  logic                                   mem_cmd_last_i,

   output logic [cce_mem_msg_header_width_lp-1:0] mem_resp_header_o,
   output logic                                   mem_resp_header_v_o,
   input  logic                                   mem_resp_header_ready_and_i,
   output logic                                   mem_resp_has_data_o,
   output logic [dword_width_gp-1:0]              mem_resp_data_o,
   output logic                                   mem_resp_data_v_o,
   input  logic                                   mem_resp_data_ready_and_i,
   output logic                                   mem_resp_last_o,

   output logic                                   ram_v_o,
   output logic                                   ram_w_o,
   output logic [paddr_width_p-4:0]               ram_addr_o,
   output logic [dword_width_gp-1:0]              ram_data_o,
   output logic [dword_width_gp/8-1:0]            ram_mask_o,
   input  logic [dword_width_gp-1:0]              ram_data_i,

   output logic                                   error_o
);
   localparam int cnt_width_lp = $clog2(cce_block_width_p/64) + 1;

   bp_bedrock_mem_header_s    header_q, header_d, header_in;
   bp_me_state_t              state_q, state_d;
   logic [cnt_width_lp-1:0]   cnt_q, cnt_d;
   logic [dword_width_gp-1:0] rdata_q, rdata_d;
   logic                      error_q, error_d;
   logic                      rd_first_q, rd_first_d;
   logic                      is_wr_in, is_wr_q, last_beat, hdr_ready;

   assign header_in = bp_bedrock_mem_header_s'(mem_cmd_header_i);
   assign is_wr_in  = (header_in.msg_type == e_bedrock_mem_wr) || (header_in.msg_type == e_bedrock_mem_uc_wr);
   assign is_wr_q   = (header_q.msg_type == e_bedrock_mem_wr) || (header_q.msg_type == e_bedrock_mem_uc_wr);

   bp_me_burst_addr_gen #(
      .paddr_width_p (paddr_width_p),
      .cnt_width_p   (cnt_width_lp),
      .mask_width_p  (dword_width_gp/8)
   ) u_addr_gen (
      .addr_i     (header_q.addr),
      .size_i     (header_q.size),
      .cnt_i      (cnt_q),
      .ram_addr_o (ram_addr_o),
      .mask_o     (ram_mask_o),
      .last_o     (last_beat)
   );

   always_comb begin
      state_d    = state_q;
      header_d   = header_q;
      cnt_d      = cnt_q;
      error_d    = error_q;
      rdata_d    = rdata_q;
      rd_first_d = 1'b0;
      hdr_ready                = 1'b0;
      mem_cmd_data_ready_and_o = 1'b0;
      mem_resp_header_v_o      = 1'b0;
      mem_resp_data_v_o        = 1'b0;
      mem_resp_last_o          = 1'b0;
      ram_v_o                  = 1'b0;
      ram_w_o                  = 1'b0;
      case (state_q)
         e_ready: begin
            hdr_ready = 1'b1;
            if (mem_cmd_header_v_i) begin
               header_d = header_in;
               cnt_d    = '0;
               if (mem_cmd_has_data_i != is_wr_in) error_d = 1'b1;
               state_d  = is_wr_in ? e_write : e_resp_hdr;
            end
         end
         e_write: begin
            mem_cmd_data_ready_and_o = 1'b1;
            if (mem_cmd_data_v_i) begin
               ram_v_o = 1'b1;
               ram_w_o = 1'b1;
               // The computed beat count, not the sender's last flag, ends the burst
               if (mem_cmd_last_i != last_beat) error_d = 1'b1;
               if (last_beat) state_d = e_resp_hdr;
               else           cnt_d   = cnt_q + cnt_width_lp'(1);
            end
         end
         e_resp_hdr: begin
            mem_resp_header_v_o = 1'b1;
            if (mem_resp_header_ready_and_i) state_d = is_wr_q ? e_ready : e_read_issue;
         end
         e_read_issue: begin
            ram_v_o    = 1'b1;
            rd_first_d = 1'b1;
            state_d    = e_read_data;
         end
         e_read_data: begin
            mem_resp_data_v_o = 1'b1;
            mem_resp_last_o   = last_beat;
            if (rd_first_q) rdata_d = ram_data_i;
            if (mem_resp_data_ready_and_i) begin
               if (last_beat) state_d = e_ready;
               else begin
                  cnt_d   = cnt_q + cnt_width_lp'(1);
                  state_d = e_read_issue;
               end
            end
         end
         default: state_d = e_ready;
      endcase
   end

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         state_q    <= e_ready;
         header_q   <= '0;
         cnt_q      <= '0;
         error_q    <= 1'b0;
         rdata_q    <= '0;
         rd_first_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         header_q   <= header_d;
         cnt_q      <= cnt_d;
         error_q    <= error_d;
         rdata_q    <= rdata_d;
         rd_first_q <= rd_first_d;
      end
   end

   // RAM read data is only valid in the first data cycle; later cycles replay the hold register
   assign mem_resp_data_o            = rd_first_q ? ram_data_i : rdata_q;
   assign mem_cmd_header_ready_and_o = hdr_ready & ~reset_i;
   assign mem_resp_header_o          = header_q;
   assign mem_resp_has_data_o        = ~is_wr_q;
   assign ram_data_o                 = mem_cmd_data_i;
   assign error_o                    = error_q;

endmodule
`default_nettype wire

// File: tb/tb_bp_me_burst_mem_slave.sv
`default_nettype none
// ============================================================================
// tb_bp_me_burst_mem_slave: directed self-checking bench for the burst slave
// Revision: 1.0
// ============================================================================
module tb_bp_me_burst_mem_slave;
   import bp_me_pkg::*;

   localparam int HW = $bits(bp_bedrock_mem_header_s);
   localparam int AW = paddr_width_gp - 3;

   logic          clk = 1'b0;
   logic          reset_i;
   logic [HW-1:0] cmd_hdr;
   logic          cmd_hdr_v, cmd_hdr_ready, cmd_has_data;
   logic [63:0]   cmd_data;
   logic          cmd_data_v, cmd_data_ready, cmd_last;
   logic [HW-1:0] resp_hdr;
   logic          resp_hdr_v, resp_hdr_ready, resp_has_data;
   logic [63:0]   resp_data;
   logic          resp_data_v, resp_data_ready, resp_last;
   logic          ram_v, ram_w;
   logic [AW-1:0] ram_addr;
   logic [63:0]   ram_wdata, ram_rdata;
   logic [7:0]    ram_mask;
   logic          error;

   int tests_run    = 0;
   int tests_failed = 0;

   always #5 clk = ~clk;

   bp_me_burst_mem_slave dut (
      .clk_i                       (clk),
      .reset_i                     (reset_i),
      .mem_cmd_header_i            (cmd_hdr),
      .mem_cmd_header_v_i          (cmd_hdr_v),
      .mem_cmd_header_ready_and_o  (cmd_hdr_ready),
      .mem_cmd_has_data_i          (cmd_has_data),
      .mem_cmd_data_i              (cmd_data),
      .mem_cmd_data_v_i            (cmd_data_v),
      .mem_cmd_data_ready_and_o    (cmd_data_ready),
      .mem_cmd_last_i              (cmd_last),
      .mem_resp_header_o           (resp_hdr),
      .mem_resp_header_v_o         (resp_hdr_v),
      .mem_resp_header_ready_and_i (resp_hdr_ready),
      .mem_resp_has_data_o         (resp_has_data),
      .mem_resp_data_o             (resp_data),
      .mem_resp_data_v_o           (resp_data_v),
      .mem_resp_data_ready_and_i   (resp_data_ready),
      .mem_resp_last_o             (resp_last),
      .ram_v_o                     (ram_v),
      .ram_w_o                     (ram_w),
      .ram_addr_o                  (ram_addr),
      .ram_data_o                  (ram_wdata),
      .ram_mask_o                  (ram_mask),
      .ram_data_i                  (ram_rdata),
      .error_o                     (error)
   );

   function automatic logic [63:0] rd_pattern(input logic [AW-1:0] a);
      return {27'h5A5A5A5, a};
   endfunction

   // RAM returns data one cycle after a read strobe and garbage otherwise
   always @(posedge clk)
      ram_rdata <= (ram_v && !ram_w) ? rd_pattern(ram_addr) : 64'hBAD0_BAD0_BAD0_BAD0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      tests_run++;
      if (got !== exp) begin
         tests_failed++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic bp_bedrock_mem_header_s mk_hdr(input bp_bedrock_mem_type_e t,
                                                     input bp_bedrock_msg_size_e s,
                                                     input logic [paddr_width_gp-1:0] a);
      bp_bedrock_mem_header_s h;
      h                = '0;
      h.msg_type       = t;
      h.size           = s;
      h.addr           = a;
      h.payload.lce_id = 4'h3;
      h.payload.way_id = 3'h5;
      return h;
   endfunction

   task automatic check_all_idle(input string tag);
      check({tag, "_hdr_rdy"},  64'(cmd_hdr_ready),  64'd0);
      check({tag, "_data_rdy"}, 64'(cmd_data_ready), 64'd0);
      check({tag, "_resp_hv"},  64'(resp_hdr_v),     64'd0);
      check({tag, "_resp_dv"},  64'(resp_data_v),    64'd0);
      check({tag, "_ram_v"},    64'(ram_v),          64'd0);
      check({tag, "_error"},    64'(error),          64'd0);
   endtask

   // Entered at a negedge; leaves at the following negedge with the header accepted
   task automatic send_hdr(input bp_bedrock_mem_header_s h, input logic has_data);
      cmd_hdr      = h;
      cmd_hdr_v    = 1'b1;
      cmd_has_data = has_data;
      #1;
      check("hdr_ready", 64'(cmd_hdr_ready), 64'd1);
      @(negedge clk);
      cmd_hdr_v    = 1'b0;
      cmd_has_data = 1'b0;
   endtask

   task automatic resp_hdr_phase(input bp_bedrock_mem_header_s h, input logic exp_has_data);
      #1;
      check("resp_hdr_v",    64'(resp_hdr_v),    64'd1);
      check("resp_has_data", 64'(resp_has_data), 64'(exp_has_data));
      check("resp_hdr",      64'(resp_hdr),      64'(h));
      check("resp_hdr_ramv", 64'(ram_v),         64'd0);
      check("busy_hdr_rdy",  64'(cmd_hdr_ready), 64'd0);
      resp_hdr_ready = 1'b1;
      @(negedge clk);
      resp_hdr_ready = 1'b0;
   endtask

   task automatic run_write(input bp_bedrock_mem_header_s h, input int n, input int last_at,
                            input logic [63:0] wdata, input logic [AW-1:0] exp_addr [8],
                            input logic [7:0] exp_mask);
      send_hdr(h, 1'b1);
      for (int i = 0; i < n; i++) begin
         cmd_data   = wdata + 64'(i);
         cmd_data_v = 1'b1;
         cmd_last   = (i == last_at);
         #1;
         check("wr_data_rdy", 64'(cmd_data_ready), 64'd1);
         check("wr_ram_v",    64'(ram_v),          64'd1);
         check("wr_ram_w",    64'(ram_w),          64'd1);
         check("wr_addr",     64'(ram_addr),       64'(exp_addr[i]));
         check("wr_mask",     64'(ram_mask),       64'(exp_mask));
         check("wr_data",     ram_wdata,           wdata + 64'(i));
         @(negedge clk);
      end
      cmd_data_v = 1'b0;
      cmd_last   = 1'b0;
      resp_hdr_phase(h, 1'b0);
   endtask

   task automatic run_read(input bp_bedrock_mem_header_s h, input int n, input logic [AW-1:0] exp_addr [8],
                           input int stall_beat, input int stall_cycles, input int abort_beat);
      logic [63:0] exp_d;
      send_hdr(h, 1'b0);
      resp_hdr_phase(h, 1'b1);
      for (int i = 0; i < n; i++) begin
         #1;
         check("rd_issue_v",   64'(ram_v),       64'd1);
         check("rd_issue_w",   64'(ram_w),       64'd0);
         check("rd_addr",      64'(ram_addr),    64'(exp_addr[i]));
         check("rd_issue_dv",  64'(resp_data_v), 64'd0);
         if (i == abort_beat) begin
            reset_i = 1'b1;
            #1;
            check_all_idle("abort_now");
            @(negedge clk);
            #1;
            check_all_idle("abort_next");
            reset_i = 1'b0;
            #1;
            check("post_abort_rdy", 64'(cmd_hdr_ready), 64'd1);
            return;
         end
         @(negedge clk);
         #1;
         exp_d = rd_pattern(exp_addr[i]);
         check("rd_dv",   64'(resp_data_v), 64'd1);
         check("rd_data", resp_data,        exp_d);
         check("rd_last", 64'(resp_last),   64'(i == n - 1));
         check("rd_ramv", 64'(ram_v),       64'd0);
         if (i == stall_beat) begin
            for (int s = 0; s < stall_cycles; s++) begin
               @(negedge clk);
               #1;
               check("stall_dv",   64'(resp_data_v), 64'd1);
               check("stall_data", resp_data,        exp_d);
               check("stall_ramv", 64'(ram_v),       64'd0);
            end
         end
         resp_data_ready = 1'b1;
         @(negedge clk);
         resp_data_ready = 1'b0;
      end
      #1;
      check("rd_done_rdy", 64'(cmd_hdr_ready), 64'd1);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [AW-1:0] a [8];
      reset_i         = 1'b1;
      cmd_hdr         = '0;
      cmd_hdr_v       = 1'b0;
      cmd_has_data    = 1'b0;
      cmd_data        = '0;
      cmd_data_v      = 1'b0;
      cmd_last        = 1'b0;
      resp_hdr_ready  = 1'b0;
      resp_data_ready = 1'b0;
      @(negedge clk);
      @(negedge clk);
      #1;
      check_all_idle("reset");
      @(negedge clk);
      reset_i = 1'b0;

      // 8B uncached write
      a = '{default: '0};
      a[0] = 37'h10000001;
      run_write(mk_hdr(e_bedrock_mem_uc_wr, e_bedrock_msg_size_8, 40'h80000008), 1, 0,
                64'h0000_0000_0000_DEAD, a, 8'hFF);

      // 2B uncached write: byte lanes 6 and 7
      a[0] = 37'h10000000;
      run_write(mk_hdr(e_bedrock_mem_uc_wr, e_bedrock_msg_size_2, 40'h80000006), 1, 0,
                64'h0000_0000_0000_BEEF, a, 8'hC0);

      // 64B read, critical word first from dword 3
      a = '{37'h10000003, 37'h10000004, 37'h10000005, 37'h10000006,
            37'h10000007, 37'h10000000, 37'h10000001, 37'h10000002};
      run_read(mk_hdr(e_bedrock_mem_rd, e_bedrock_msg_size_64, 40'h80000018), 8, a, -1, 0, -1);

      // 64B read with back-pressure on beat 2
      a = '{37'h10000000, 37'h10000001, 37'h10000002, 37'h10000003,
            37'h10000004, 37'h10000005, 37'h10000006, 37'h10000007};
      run_read(mk_hdr(e_bedrock_mem_rd, e_bedrock_msg_size_64, 40'h80000000), 8, a, 1, 5, -1);
      check("error_clean", 64'(error), 64'd0);

      // 64B write with an early last flag
      run_write(mk_hdr(e_bedrock_mem_wr, e_bedrock_msg_size_64, 40'h80000000), 8, 3,
                64'h1111_2222_3333_0000, a, 8'hFF);
      #1;
      check("error_set", 64'(error), 64'd1);

      // Reset in the middle of beat 3 of a 64B read
      run_read(mk_hdr(e_bedrock_mem_rd, e_bedrock_msg_size_64, 40'h80000000), 8, a, -1, 0, 2);
      @(negedge clk);

      // Fresh reads after the abort: full dword and sub-dword
      a = '{default: '0};
      a[0] = 37'h10000002;
      run_read(mk_hdr(e_bedrock_mem_rd, e_bedrock_msg_size_8, 40'h80000010), 1, a, -1, 0, -1);
      @(negedge clk);
      a[0] = 37'h10000000;
      run_read(mk_hdr(e_bedrock_mem_uc_rd, e_bedrock_msg_size_2, 40'h80000006), 1, a, -1, 0, -1);
      check("error_final", 64'(error), 64'd0);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
`default_nettype wire
